// File: rtl/inst_fetch_if.sv
// Fetch-side bus between the instruction supply and its controller/datapath:
// program-load port, flow control (start/stall/redirect) and fetched-instruction outputs.
interface inst_fetch_if #(
   parameter int AW = 8
);
   logic          start;
   logic          load_en;
   logic [AW-1:0] load_addr;
   logic [31:0]   load_data;
   logic          stall;
   logic          redirect;
   logic [31:0]   redirect_pc;
   logic [31:0]   Inst;
   logic [31:0]   inst_pc;
   logic          inst_valid;
   logic          halted;
   logic [31:0]   fetch_count;

   modport master (
      output start, load_en, load_addr, load_data, stall, redirect, redirect_pc,
      input  Inst, inst_pc, inst_valid, halted, fetch_count
   );

   modport slave (
      input  start, load_en, load_addr, load_data, stall, redirect, redirect_pc,
      output Inst, inst_pc, inst_valid, halted, fetch_count
   );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch unit: program memory, PC sequencing with stall/redirect squash,
// halt-word detection and a count of delivered instructions.
module inst_fetch #(
   parameter int          DEPTH     = 256,
   parameter int          AW        = 8,
   parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input logic         clk,
   input logic         rst,
   inst_fetch_if.slave bus
);

   typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] inst_p0, inst_next;
   logic [31:0] inst_pc_p0, inst_pc_next;
   logic        vld_p0, vld_next;
   logic        halted, halted_next;
   logic [31:0] count, count_next;

   logic [31:0] mem [DEPTH];
   logic [31:0] mem_word;

   // Only the word-index bits of pc select memory, so addresses alias every 4*DEPTH bytes.
   assign mem_word = mem[pc[AW+1:2]];

   always_ff @(posedge clk) begin
      if (!rst && state == IDLE && bus.load_en)
         mem[bus.load_addr] <= bus.load_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= '0;
         inst_p0    <= '0;
         inst_pc_p0 <= '0;
         vld_p0     <= 1'b0;
         halted     <= 1'b0;
         count      <= '0;
      end else begin
         state      <= state_next;
         pc         <= pc_next;
         inst_p0    <= inst_next;
         inst_pc_p0 <= inst_pc_next;
         vld_p0     <= vld_next;
         halted     <= halted_next;
         count      <= count_next;
      end
   end

   always_comb begin
      state_next   = state;
      pc_next      = pc;
      inst_next    = inst_p0;
      inst_pc_next = inst_pc_p0;
      vld_next     = vld_p0;
      halted_next  = halted;
      count_next   = count;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_next = FETCH;
               pc_next    = '0;
            end
         end
         FETCH: begin
            // Redirect squashes the in-flight slot but keeps the last Inst/inst_pc visible.
            if (bus.redirect) begin
               pc_next  = bus.redirect_pc & ~32'd3;
               vld_next = 1'b0;
            end else if (!bus.stall) begin
               inst_next    = mem_word;
               inst_pc_next = pc;
               pc_next      = pc + 32'd4;
               if (mem_word == HALT_WORD) begin
                  vld_next    = 1'b0;
                  halted_next = 1'b1;
                  state_next  = HALT;
               end else begin
                  vld_next   = 1'b1;
                  count_next = count + 32'd1;
               end
            end
         end
         HALT: begin
            if (bus.start) begin
               state_next  = FETCH;
               pc_next     = '0;
               halted_next = 1'b0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign bus.Inst        = inst_p0;
   assign bus.inst_pc     = inst_pc_p0;
   assign bus.inst_valid  = vld_p0;
   assign bus.halted      = halted;
   assign bus.fetch_count = count;

endmodule
